// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle shift unit controller that sits beside the ALU. Instead of a
// barrel shifter it moves a working register one bit per clock, so a shift
// by N takes N cycles plus fixed handshake overhead. Main control hands it
// a shift instruction with a start pulse and waits for the done pulse.
//
// Supported operations (op):
//   2'b00  sll  logical shift left
//   2'b01  srl  logical shift right
//   2'b10  sra  arithmetic shift right (sign bit replicated)
//   2'b11  ror  rotate right
//
// Ports:
//   clk      in   1      system clock, rising edge active
//   rst_n    in   1      asynchronous reset, active low
//   start    in   1      request a shift; only looked at while idle
//   op       in   2      shift operation select (see table above)
//   shamt    in   SHW    shift amount from the instruction shamt field
//   data_in  in   WIDTH  operand to shift (rt value)
//   busy     out  1      high whenever the unit is not idle
//   done     out  1      one-cycle pulse when result is valid
//   result   out  WIDTH  shifted value; holds until the next accepted start
// ---------------------------------------------------------------------------
module shift_sequencer #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [SHW-1:0]   shamt,
   input  logic [WIDTH-1:0] data_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] next_work;
   logic [SHW-1:0]   count;
   logic [SHW-1:0]   next_count;
   logic [1:0]       op_q;
   logic [1:0]       next_op;

   // The working register is the result; consumers only trust it while done
   // is high, and it holds its final value through idle.
   assign result = work;

   // Next-state and datapath decode. The operands are captured only on the
   // accept edge, so later changes to op/shamt/data_in have no effect. The
   // count holds the remaining number of one-bit steps; a count of zero in
   // SHIFT means the work is finished, so the unit spends exactly one extra
   // cycle there before DONE, which gives the shamt+1 latency to done.
   always_comb begin
      next_state = state;
      next_work  = work;
      next_count = count;
      next_op    = op_q;
      case (state)
         IDLE: begin
            if (start) begin
               next_work  = data_in;
               next_count = shamt;
               next_op    = op;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (count != '0) begin
               case (op_q)
                  OP_SLL:  next_work = {work[WIDTH-2:0], 1'b0};
                  OP_SRL:  next_work = {1'b0, work[WIDTH-1:1]};
                  OP_SRA:  next_work = {work[WIDTH-1], work[WIDTH-1:1]};
                  OP_ROR:  next_work = {work[0], work[WIDTH-1:1]};
                  default: next_work = work;
               endcase
               next_count = count - SHW'(1);
            end else begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State and datapath registers. busy and done are registered straight
   // from the decoded next state so they carry no combinational path from
   // the inputs. Reset drops everything at once, which aborts an operation
   // in flight without ever producing a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         work  <= '0;
         count <= '0;
         op_q  <= 2'b00;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= next_state;
         work  <= next_work;
         count <= next_count;
         op_q  <= next_op;
         busy  <= (next_state != IDLE);
         done  <= (next_state == DONE);
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
//
// Directed self-checking bench for shift_sequencer. Each vector carries a
// hand-computed result and done latency counted in clock edges after the
// accept edge. Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [4:0]  shamt;
   logic [31:0] data_in;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks;
   int errors;

   shift_sequencer #(.WIDTH(32), .SHW(5)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .shamt   (shamt),
      .data_in (data_in),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Present a request on the falling edge, let the next rising edge accept
   // it, then drop start.
   task automatic applyStimulus(input logic [1:0] o, input logic [4:0] s,
                                input logic [31:0] d);
      @(negedge clk);
      op      = o;
      shamt   = s;
      data_in = d;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges from the accept edge until done rises (bounded), returning
   // the number of edges taken; 99 means the bound expired.
   task automatic waitDone(output int edges);
      edges = 99;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            edges = n;
            break;
         end
      end
   endtask

   // Full operation: accept, wait for done, check latency and result, then
   // check that done was a single pulse and the unit went idle.
   task automatic runShift(input string tag, input logic [1:0] o,
                           input logic [4:0] s, input logic [31:0] d,
                           input logic [31:0] exp_result);
      int edges;
      applyStimulus(o, s, d);
      checkOutput({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
      waitDone(edges);
      checkOutput({tag, "_latency"}, 32'(edges), 32'(s) + 32'd1);
      checkOutput({tag, "_result"}, result, exp_result);
      @(posedge clk);
      #1;
      checkOutput({tag, "_done_drop"}, 32'(done), 32'd0);
      checkOutput({tag, "_busy_drop"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int edges;
      logic seen_done;
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      start   = 1'b1;
      op      = 2'b00;
      shamt   = 5'd0;
      data_in = 32'hFFFF_FFFF;

      // Reset held for 3 cycles with start high.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_result", result, 32'd0);
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("post_reset_idle", 32'(busy), 32'd0);

      // Main function vectors.
      runShift("sll4", 2'b00, 5'd4, 32'h0000_0001, 32'h0000_0010);
      runShift("sra31", 2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
      runShift("srl31", 2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001);
      runShift("ror4", 2'b11, 5'd4, 32'h0000_000F, 32'hF000_0000);
      runShift("zero", 2'b00, 5'd0, 32'h1234_5678, 32'h1234_5678);
      runShift("sra4pos", 2'b10, 5'd4, 32'h7000_0000, 32'h0700_0000);

      // Result holds in idle.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("idle_hold", result, 32'h0700_0000);

      // Busy ignore: start with new operands during an 8-bit sll.
      applyStimulus(2'b00, 5'd8, 32'h0000_00FF);
      @(negedge clk);
      start   = 1'b1;
      data_in = 32'hDEAD_BEEF;
      op      = 2'b10;
      shamt   = 5'd3;
      @(negedge clk);
      op      = 2'b11;
      shamt   = 5'd1;
      @(negedge clk);
      start   = 1'b0;
      edges = 99;
      for (int n = 3; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            edges = n;
            break;
         end
      end
      checkOutput("ignore_latency", 32'(edges), 32'd9);
      checkOutput("ignore_result", result, 32'h0000_FF00);

      // Start raised during DONE: ignored there, accepted on the first idle edge.
      op      = 2'b00;
      shamt   = 5'd1;
      data_in = 32'h0000_0001;
      start   = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("held_idle_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("held_accept_busy", 32'(busy), 32'd1);
      start = 1'b0;
      waitDone(edges);
      checkOutput("held_latency", 32'(edges), 32'd2);
      checkOutput("held_result", result, 32'h0000_0002);
      @(posedge clk);
      #1;

      // Reset on the third SHIFT cycle of a 10-bit shift.
      applyStimulus(2'b00, 5'd10, 32'h0000_0001);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_result", result, 32'd0);
      seen_done = 1'b0;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk);
         #1;
         if (done) seen_done = 1'b1;
      end
      checkOutput("midrst_no_done", 32'(seen_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      runShift("after_rst", 2'b00, 5'd2, 32'h0000_0003, 32'h0000_000C);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
